tomasulo_rs_multi: RTL and testbench
====================================

# tomasulo_rs_multi

Parametrised reservation station for the Tomasulo pipeline. It sits between the dispatch stage and one functional unit (arith, logic or mpy) and holds up to ENTRIES_N renamed instructions. Each entry snoops CDB_N common data buses for its outstanding operand tags. Entries whose operands are all present issue to the unit through a valid/ready handshake.

## Interface
- ENTRIES_N, 4: number of station entries (≥2).
- CDB_N, 2: number of CDB broadcast channels snooped (≥1).
- TAG_W, 5: producer tag width.
- WORD_W, 32: operand/result width.
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all entries.
- disp_vld  in  1  dispatch request.
- disp_rdy  out  1  a free entry exists.
- disp_op  in  4  opcode_t.
- disp_tag  in  TAG_W  destination tag.
- disp_busy  in  2  per operand: 1 means the operand is pending and disp_opr[i][TAG_W-1:0] holds its tag.
- disp_opr  in  2×WORD_W  operand value or padded tag.
- disp_imm  in  WORD_W  immediate.
- cdb_vld  in  CDB_N  per-channel broadcast valid.
- cdb_tag  in  CDB_N×TAG_W  broadcast tags.
- cdb_wdata  in  CDB_N×WORD_W  broadcast data.
- iss_vld  out  1  issue valid.
- iss_rdy  in  1  functional unit accepts.
- iss_op / iss_tag / iss_rdata / iss_imm  out  4 / TAG_W / 2×WORD_W / WORD_W  issue payload.
- occupancy  out  $clog2(ENTRIES_N+1)  valid entry count.

## Operation
- Entry state: vld, op, tag, imm, and two operands, each holding busy plus a word.
- Dispatch: on disp_vld&&disp_rdy, write the lowest-index free entry.
  - Same-cycle bypass is mandatory: a busy dispatch operand whose tag matches any cdb_vld channel in the same cycle is written as ready with that channel's data.
- Wake-up: every valid entry compares each busy operand against all CDB channels. On a match, busy clears and the data is captured.
  - If several channels match, the lowest channel index wins.
- Ready: an entry is ready when vld is set and both operands are not busy.
- Issue select: one ready entry is chosen (policy under Configuration) and drives the iss_* outputs.
- Hold lock: when iss_vld=1 and iss_rdy=0, the selected index is locked. The payload is held stable until the handshake completes, and no re-arbitration happens.
- Handshake: on iss_vld&&iss_rdy the entry is freed.
- occupancy: +1 on dispatch accept, −1 on issue accept; both in the same cycle leave it unchanged.
- disp_rdy = (occupancy≠ENTRIES_N) && !rst && !flush. It does not look at iss_rdy, so there is no same-cycle reuse of a freed slot.
- flush: all vld, the lock and occupancy clear. A dispatch in the flush cycle is dropped. iss_vld is forced to 0 in the flush cycle.
- Reset: identical to flush, and also clears payload registers to 0.
- Reset values of outputs: disp_rdy=0 while rst is high and 1 the cycle after; iss_vld=0; iss_* payload=0; occupancy=0.

## Timing
- Dispatch with both operands ready at cycle t gives iss_vld at t+1 at the earliest.
- CDB match at cycle t (dispatch bypass or wake-up) makes the entry eligible at t+1.
- Issue outputs are combinational from entry state plus the lock register. No combinational path exists from disp_* or cdb_* to iss_*.
- Full: a dispatch at occupancy=ENTRIES_N−1 makes disp_rdy=0 the next cycle. It returns to 1 the cycle after an issue accept.
- Back-to-back issue: one entry per cycle while iss_rdy=1.

## Configuration
- TOMASULO_RS_AGE_EN defined: the oldest ready entry issues, tracked with an ENTRIES_N×ENTRIES_N age matrix.
  - On dispatch, the new entry's row is cleared; every other valid entry's bit for the new entry is set.
- Not defined: the lowest-index ready entry issues and there is no age state.
- Handshake, lock and bypass behaviour are identical in both builds.

## Structure
- Shared package tomasulo_pkg supplies:
  - opcode_t, tag_t, word_t, imm_t, cdb_t, oprand_t.
  - RS_N as the default for ENTRIES_N.
  - A new typedef rs_entry_t {vld, op, tag, oprand_t[1:0], imm}.
- Sub-module tomasulo_rs_age_matrix (ENTRIES_N) takes ready and alloc one-hot and returns a one-hot oldest-ready select. It is instantiated only under TOMASULO_RS_AGE_EN.

## Test plan
- Single ready op: reset, dispatch ADD tag=3 with operands 5 and 7 ready, iss_rdy=1 → iss_vld at t+1 with iss_tag=3, iss_rdata={7,5}; occupancy goes 1→0.
- Wake-up: dispatch with operand0 busy on tag=9, then drive cdb[1] tag=9 data=0xDEAD 3 cycles later → issue in the following cycle with rdata[0]=0xDEAD.
- Bypass: dispatch busy tag=4 in the same cycle cdb[0] broadcasts tag=4 data=0x11 → issue next cycle with 0x11.
- Full/backpressure: iss_rdy=0, dispatch 4 ready entries → disp_rdy=0 and the first selected payload stays stable for 10 cycles; raising iss_rdy drains all 4, one per cycle.
- Ordering (macro on): dispatch entries tag=1 (busy), then tag=2 (ready), then wake tag=1 → tag=1 issues before tag=2 if both are ready together. Macro off → the lower index issues first.
- Flush: with 3 valid entries and a concurrent dispatch, assert flush → occupancy=0, iss_vld=0 the next cycle, and the dispatched op never issues.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// ---------------------------------------------------------------------------
// tomasulo_pkg
// Shared types for the Tomasulo pipeline: opcodes, tag/word types, CDB
// broadcast record, operand record and the reservation-station entry record.
// RS_N is the default station depth used by tomasulo_rs_multi.
// No ports (package only).
// ---------------------------------------------------------------------------
package tomasulo_pkg;

   localparam int RS_N       = 4;
   localparam int PKG_TAG_W  = 5;
   localparam int PKG_WORD_W = 32;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SLL = 4'd5,
      OP_SRL = 4'd6,
      OP_MUL = 4'd7
   } opcode_t;

   typedef logic [PKG_TAG_W-1:0]  tag_t;
   typedef logic [PKG_WORD_W-1:0] word_t;
   typedef word_t                 imm_t;

   typedef struct packed {
      logic  vld;
      tag_t  tag;
      word_t data;
   } cdb_t;

   // While busy is set, the low tag bits of val hold the producer tag.
   typedef struct packed {
      logic  busy;
      word_t val;
   } oprand_t;

   typedef struct packed {
      logic             vld;
      opcode_t          op;
      tag_t             tag;
      oprand_t [1:0]    opr;
      imm_t             imm;
   } rs_entry_t;

endpackage

// File: rtl/tomasulo_rs_age_matrix.sv
// ---------------------------------------------------------------------------
// tomasulo_rs_age_matrix
// Relative-age tracker for the reservation station. older[i][j] set means
// entry i was allocated before entry j. Returns a one-hot select of the
// oldest entry among those flagged ready (all zero when none are ready).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   alloc     - one-hot (or zero) entry being allocated this cycle
//   ready     - per-entry ready flags
//   oldest    - one-hot oldest ready entry
// ---------------------------------------------------------------------------
module tomasulo_rs_age_matrix #(
   parameter int ENTRIES_N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ENTRIES_N-1:0] alloc,
   input  logic [ENTRIES_N-1:0] ready,
   output logic [ENTRIES_N-1:0] oldest
);

   logic [ENTRIES_N-1:0] older [ENTRIES_N];

   // A freshly allocated entry is younger than everyone: its row is cleared
   // and every other row marks it as younger. Bits held by free entries are
   // stale but harmless, since they are only consulted between ready entries
   // and a row is rewritten whenever its entry is allocated again.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES_N; i++) begin
            older[i] <= '0;
         end
      end else begin
         for (int n = 0; n < ENTRIES_N; n++) begin
            if (alloc[n]) begin
               older[n] <= '0;
               for (int k = 0; k < ENTRIES_N; k++) begin
                  if (k != n) begin
                     older[k][n] <= 1'b1;
                  end
               end
            end
         end
      end
   end

   // An entry wins when it is ready and older than every other ready entry.
   always_comb begin
      for (int i = 0; i < ENTRIES_N; i++) begin
         oldest[i] = ready[i];
         for (int j = 0; j < ENTRIES_N; j++) begin
            if (j != i && ready[j] && !older[i][j]) begin
               oldest[i] = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/tomasulo_rs_multi.sv
// ---------------------------------------------------------------------------
// tomasulo_rs_multi
// Reservation station between dispatch and one functional unit. Holds up to
// ENTRIES_N renamed instructions, snoops CDB_N broadcast channels for pending
// operand tags, and issues ready entries over a valid/ready handshake with a
// hold lock while the unit stalls.
// Build option: define TOMASULO_RS_AGE_EN to issue the oldest ready entry
// (age matrix); otherwise the lowest-index ready entry issues.
// Ports:
//   clk, rst, flush                    - clock, sync reset, sync squash
//   disp_vld/disp_rdy + disp_op, disp_tag, disp_busy, disp_opr, disp_imm
//                                      - dispatch request and payload
//   cdb_vld, cdb_tag, cdb_wdata        - per-channel broadcast
//   iss_vld/iss_rdy + iss_op, iss_tag, iss_rdata, iss_imm
//                                      - issue handshake and payload
//   occupancy                          - number of valid entries
// ---------------------------------------------------------------------------
module tomasulo_rs_multi
   import tomasulo_pkg::*;
#(
   parameter int ENTRIES_N = RS_N,
   parameter int CDB_N     = 2,
   parameter int TAG_W     = 5,
   parameter int WORD_W    = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic                            disp_vld,
   output logic                            disp_rdy,
   input  opcode_t                         disp_op,
   input  logic [TAG_W-1:0]                disp_tag,
   input  logic [1:0]                      disp_busy,
   input  logic [1:0][WORD_W-1:0]          disp_opr,
   input  logic [WORD_W-1:0]               disp_imm,
   input  logic [CDB_N-1:0]                cdb_vld,
   input  logic [CDB_N-1:0][TAG_W-1:0]     cdb_tag,
   input  logic [CDB_N-1:0][WORD_W-1:0]    cdb_wdata,
   output logic                            iss_vld,
   input  logic                            iss_rdy,
   output opcode_t                         iss_op,
   output logic [TAG_W-1:0]                iss_tag,
   output logic [1:0][WORD_W-1:0]          iss_rdata,
   output logic [WORD_W-1:0]               iss_imm,
   output logic [$clog2(ENTRIES_N+1)-1:0]  occupancy
);

   localparam int IDX_W = $clog2(ENTRIES_N);
   localparam int OCC_W = $clog2(ENTRIES_N+1);

   logic [ENTRIES_N-1:0]    ent_vld;
   opcode_t                 ent_op   [ENTRIES_N];
   logic [TAG_W-1:0]        ent_tag  [ENTRIES_N];
   logic [WORD_W-1:0]       ent_imm  [ENTRIES_N];
   logic [1:0]              ent_busy [ENTRIES_N];
   logic [1:0][WORD_W-1:0]  ent_val  [ENTRIES_N];

   logic                    lock_vld;
   logic [IDX_W-1:0]        lock_idx;

   logic [1:0]              wake_hit  [ENTRIES_N];
   logic [1:0][WORD_W-1:0]  wake_data [ENTRIES_N];
   logic [1:0]              new_busy;
   logic [1:0][WORD_W-1:0]  new_val;
   logic [ENTRIES_N-1:0]    ready;
   logic [IDX_W-1:0]        free_idx;
   logic [IDX_W-1:0]        pick_idx;
   logic [IDX_W-1:0]        sel_idx;
   logic                    disp_acc;
   logic                    iss_acc;

   // Looks a tag up on the CDB. The scan runs from the highest channel down
   // so the lowest matching channel is the one left in d.
   function automatic logic cdb_lookup(input logic [TAG_W-1:0] t,
                                       output logic [WORD_W-1:0] d);
      cdb_lookup = 1'b0;
      d = '0;
      for (int c = CDB_N-1; c >= 0; c--) begin
         if (cdb_vld[c] && cdb_tag[c] == t) begin
            cdb_lookup = 1'b1;
            d = cdb_wdata[c];
         end
      end
   endfunction

   // Wake-up matches for stored operands, plus the same-cycle bypass for an
   // operand arriving on the dispatch port.
   always_comb begin
      logic [WORD_W-1:0] d;
      logic              hit;
      for (int i = 0; i < ENTRIES_N; i++) begin
         for (int k = 0; k < 2; k++) begin
            hit = cdb_lookup(ent_val[i][k][TAG_W-1:0], d);
            wake_hit[i][k]  = ent_vld[i] && ent_busy[i][k] && hit;
            wake_data[i][k] = d;
         end
      end
      for (int k = 0; k < 2; k++) begin
         hit = cdb_lookup(disp_opr[k][TAG_W-1:0], d);
         new_busy[k] = disp_busy[k];
         new_val[k]  = disp_opr[k];
         if (disp_busy[k] && hit) begin
            new_busy[k] = 1'b0;
            new_val[k]  = d;
         end
      end
   end

   // Ready flags and the lowest free slot for the next dispatch.
   always_comb begin
      free_idx = '0;
      for (int i = ENTRIES_N-1; i >= 0; i--) begin
         ready[i] = ent_vld[i] && (ent_busy[i] == 2'b00);
         if (!ent_vld[i]) begin
            free_idx = IDX_W'(i);
         end
      end
   end

   assign disp_rdy = (occupancy != OCC_W'(ENTRIES_N)) && !rst && !flush;
   assign disp_acc = disp_vld && disp_rdy;

`ifdef TOMASULO_RS_AGE_EN
   logic [ENTRIES_N-1:0] alloc_oh;
   logic [ENTRIES_N-1:0] oldest_oh;

   always_comb begin
      alloc_oh = '0;
      if (disp_acc) begin
         alloc_oh[free_idx] = 1'b1;
      end
   end

   tomasulo_rs_age_matrix #(
      .ENTRIES_N (ENTRIES_N)
   ) u_age (
      .clk    (clk),
      .rst    (rst),
      .alloc  (alloc_oh),
      .ready  (ready),
      .oldest (oldest_oh)
   );

   // Oldest ready entry, converted from one-hot to an index.
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < ENTRIES_N; i++) begin
         if (oldest_oh[i]) begin
            pick_idx = IDX_W'(i);
         end
      end
   end
`else
   // Lowest-index ready entry.
   always_comb begin
      pick_idx = '0;
      for (int i = ENTRIES_N-1; i >= 0; i--) begin
         if (ready[i]) begin
            pick_idx = IDX_W'(i);
         end
      end
   end
`endif

   // While the unit stalls a valid issue, the locked index overrides
   // arbitration so the payload cannot change under the handshake.
   assign sel_idx   = lock_vld ? lock_idx : pick_idx;
   assign iss_vld   = (lock_vld || (|ready)) && !flush && !rst;
   assign iss_acc   = iss_vld && iss_rdy;
   assign iss_op    = ent_op[sel_idx];
   assign iss_tag   = ent_tag[sel_idx];
   assign iss_rdata = ent_val[sel_idx];
   assign iss_imm   = ent_imm[sel_idx];

   // Entry storage, lock register and occupancy counter. Wake-ups are applied
   // first; the dispatch write targets a slot that is free this cycle, so it
   // never collides with a wake-up or with the entry being issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         ent_vld   <= '0;
         lock_vld  <= 1'b0;
         lock_idx  <= '0;
         occupancy <= '0;
         for (int i = 0; i < ENTRIES_N; i++) begin
            ent_op[i]   <= OP_ADD;
            ent_tag[i]  <= '0;
            ent_imm[i]  <= '0;
            ent_busy[i] <= '0;
            ent_val[i]  <= '0;
         end
      end else if (flush) begin
         ent_vld   <= '0;
         lock_vld  <= 1'b0;
         occupancy <= '0;
      end else begin
         for (int i = 0; i < ENTRIES_N; i++) begin
            for (int k = 0; k < 2; k++) begin
               if (wake_hit[i][k]) begin
                  ent_busy[i][k] <= 1'b0;
                  ent_val[i][k]  <= wake_data[i][k];
               end
            end
         end
         if (iss_acc) begin
            ent_vld[sel_idx] <= 1'b0;
         end
         if (disp_acc) begin
            ent_vld[free_idx]  <= 1'b1;
            ent_op[free_idx]   <= disp_op;
            ent_tag[free_idx]  <= disp_tag;
            ent_imm[free_idx]  <= disp_imm;
            ent_busy[free_idx] <= new_busy;
            ent_val[free_idx]  <= new_val;
         end
         lock_vld <= iss_vld && !iss_rdy;
         lock_idx <= sel_idx;
         if (disp_acc && !iss_acc) begin
            occupancy <= occupancy + OCC_W'(1);
         end else if (iss_acc && !disp_acc) begin
            occupancy <= occupancy - OCC_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_tomasulo_rs_multi.sv
// ---------------------------------------------------------------------------
// tb_tomasulo_rs_multi
// Self-checking bench for tomasulo_rs_multi: directed scenarios followed by a
// randomized phase, all compared each cycle against a slot-level behavioural
// model of the station. Honours TOMASULO_RS_AGE_EN for the issue policy.
// ---------------------------------------------------------------------------
module tb_tomasulo_rs_multi;
   import tomasulo_pkg::*;

   localparam int E  = 4;
   localparam int C  = 2;
   localparam int TW = 5;
   localparam int WW = 32;
`ifdef TOMASULO_RS_AGE_EN
   localparam bit AGE = 1'b1;
`else
   localparam bit AGE = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    flush;
   logic                    disp_vld;
   logic                    disp_rdy;
   opcode_t                 disp_op;
   logic [TW-1:0]           disp_tag;
   logic [1:0]              disp_busy;
   logic [1:0][WW-1:0]      disp_opr;
   logic [WW-1:0]           disp_imm;
   logic [C-1:0]            cdb_vld;
   logic [C-1:0][TW-1:0]    cdb_tag;
   logic [C-1:0][WW-1:0]    cdb_wdata;
   logic                    iss_vld;
   logic                    iss_rdy;
   opcode_t                 iss_op;
   logic [TW-1:0]           iss_tag;
   logic [1:0][WW-1:0]      iss_rdata;
   logic [WW-1:0]           iss_imm;
   logic [$clog2(E+1)-1:0]  occupancy;

   always #5 clk = ~clk;

   tomasulo_rs_multi #(
      .ENTRIES_N (E),
      .CDB_N     (C),
      .TAG_W     (TW),
      .WORD_W    (WW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .disp_vld  (disp_vld),
      .disp_rdy  (disp_rdy),
      .disp_op   (disp_op),
      .disp_tag  (disp_tag),
      .disp_busy (disp_busy),
      .disp_opr  (disp_opr),
      .disp_imm  (disp_imm),
      .cdb_vld   (cdb_vld),
      .cdb_tag   (cdb_tag),
      .cdb_wdata (cdb_wdata),
      .iss_vld   (iss_vld),
      .iss_rdy   (iss_rdy),
      .iss_op    (iss_op),
      .iss_tag   (iss_tag),
      .iss_rdata (iss_rdata),
      .iss_imm   (iss_imm),
      .occupancy (occupancy)
   );

   int errors = 0;
   int checks = 0;

   // Model state: one record per slot plus an allocation sequence number
   // used to find the oldest entry.
   bit          m_vld  [E];
   opcode_t     m_op   [E];
   bit [TW-1:0] m_tag  [E];
   bit [WW-1:0] m_imm  [E];
   bit          m_busy [E][2];
   bit [WW-1:0] m_val  [E][2];
   int          m_seq  [E];
   int          seq_ctr = 0;
   bit          m_lock = 1'b0;
   int          m_lock_slot = 0;

   bit          e_vld;
   bit          e_rdy;
   int          e_sel;
   int          e_occ;

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Drives dispatch and issue-ready; CDB and flush return to idle.
   task automatic applyStimulus(input bit dv, input opcode_t op, input int tag,
                                input bit [1:0] busy, input int opr0,
                                input int opr1, input int imm, input bit rdy);
      disp_vld    = dv;
      disp_op     = op;
      disp_tag    = TW'(tag);
      disp_busy   = busy;
      disp_opr[0] = WW'(opr0);
      disp_opr[1] = WW'(opr1);
      disp_imm    = WW'(imm);
      iss_rdy     = rdy;
      flush       = 1'b0;
      cdb_vld     = '0;
      cdb_tag     = '0;
      cdb_wdata   = '0;
   endtask

   task automatic setCdb(input int ch, input int tag, input int data);
      cdb_vld[ch]   = 1'b1;
      cdb_tag[ch]   = TW'(tag);
      cdb_wdata[ch] = WW'(data);
   endtask

   // Lowest CDB channel carrying tag t supplies the data.
   function automatic bit cdbFind(input bit [TW-1:0] t, output bit [WW-1:0] d);
      d = '0;
      for (int c = 0; c < C; c++) begin
         if (cdb_vld[c] && cdb_tag[c] == t) begin
            d = cdb_wdata[c];
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic bit slotReady(input int s);
      return m_vld[s] && !m_busy[s][0] && !m_busy[s][1];
   endfunction

   // Expected outputs for the current cycle from model state and inputs.
   task automatic modelEval();
      e_occ = 0;
      for (int s = 0; s < E; s++) begin
         if (m_vld[s]) e_occ++;
      end
      e_rdy = (e_occ != E) && !rst && !flush;
      e_sel = -1;
      if (m_lock) begin
         e_sel = m_lock_slot;
      end else begin
         for (int s = 0; s < E; s++) begin
            if (slotReady(s) && (e_sel < 0 || (AGE && m_seq[s] < m_seq[e_sel]))) begin
               e_sel = s;
            end
         end
      end
      e_vld = (e_sel >= 0) && !rst && !flush;
   endtask

   // Moves the model one clock edge forward.
   task automatic modelAdvance();
      int          fs;
      bit [WW-1:0] d;
      if (rst || flush) begin
         for (int s = 0; s < E; s++) m_vld[s] = 1'b0;
         m_lock = 1'b0;
      end else begin
         fs = -1;
         for (int s = E-1; s >= 0; s--) begin
            if (!m_vld[s]) fs = s;
         end
         for (int s = 0; s < E; s++) begin
            for (int k = 0; k < 2; k++) begin
               if (m_vld[s] && m_busy[s][k] && cdbFind(m_val[s][k][TW-1:0], d)) begin
                  m_busy[s][k] = 1'b0;
                  m_val[s][k]  = d;
               end
            end
         end
         if (e_vld && iss_rdy) m_vld[e_sel] = 1'b0;
         m_lock      = e_vld && !iss_rdy;
         m_lock_slot = e_sel;
         if (disp_vld && e_rdy && fs >= 0) begin
            m_vld[fs] = 1'b1;
            m_op[fs]  = disp_op;
            m_tag[fs] = disp_tag;
            m_imm[fs] = disp_imm;
            for (int k = 0; k < 2; k++) begin
               m_busy[fs][k] = disp_busy[k];
               m_val[fs][k]  = disp_opr[k];
               if (disp_busy[k] && cdbFind(disp_opr[k][TW-1:0], d)) begin
                  m_busy[fs][k] = 1'b0;
                  m_val[fs][k]  = d;
               end
            end
            m_seq[fs] = seq_ctr;
            seq_ctr++;
         end
      end
   endtask

   // Waits to mid-cycle and compares every output against the model.
   task automatic sampleCycle();
      @(negedge clk);
      modelEval();
      checkOutput("disp_rdy", disp_rdy, e_rdy);
      checkOutput("iss_vld", iss_vld, e_vld);
      if (!rst) checkOutput("occupancy", occupancy, e_occ);
      if (e_vld) begin
         checkOutput("iss_tag", iss_tag, m_tag[e_sel]);
         checkOutput("iss_op", iss_op, m_op[e_sel]);
         checkOutput("iss_rdata", iss_rdata, {m_val[e_sel][1], m_val[e_sel][0]});
         checkOutput("iss_imm", iss_imm, m_imm[e_sel]);
      end
   endtask

   task automatic endCycle();
      modelAdvance();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sampleCycle();
      endCycle();
   endtask

   initial begin
      bit [WW-1:0] w;
      int          first_tag;

      rst = 1'b1;
      applyStimulus(0, OP_ADD, 0, 2'b00, 0, 0, 0, 0);
      tick();
      tick();

      // Reset state.
      rst = 1'b0;
      sampleCycle();
      checkOutput("rst_occ", occupancy, 0);
      checkOutput("rst_rdy", disp_rdy, 1);
      checkOutput("rst_payload", {iss_op, iss_tag, iss_imm}, 0);
      checkOutput("rst_rdata", iss_rdata, 0);
      endCycle();

      // Single ready op.
      applyStimulus(1, OP_ADD, 3, 2'b00, 5, 7, 0, 1);
      tick();
      applyStimulus(0, OP_ADD, 0, 2'b00, 0, 0, 0, 1);
      sampleCycle();
      checkOutput("add_vld", iss_vld, 1);
      checkOutput("add_tag", iss_tag, 3);
      checkOutput("add_rdata", iss_rdata, {32'd7, 32'd5});
      checkOutput("add_occ1", occupancy, 1);
      endCycle();
      sampleCycle();
      checkOutput("add_occ0", occupancy, 0);
      endCycle();

      // Wake-up on channel 1 three cycles after dispatch.
      applyStimulus(1, OP_SUB, 10, 2'b01, 9, 2, 0, 1);
      tick();
      applyStimulus(0, OP_ADD, 0, 2'b00, 0, 0, 0, 1);
      tick();
      tick();
      setCdb(1, 9, 'hDEAD);
      tick();
      applyStimulus(0, OP_ADD, 0, 2'b00, 0, 0, 0, 1);
      sampleCycle();
      checkOutput("wake_vld", iss_vld, 1);
      checkOutput("wake_data", iss_rdata[0], 'hDEAD);
      endCycle();

      // Same-cycle bypass on channel 0.
      applyStimulus(1, OP_AND, 6, 2'b01, 4, 8, 0, 1);
      setCdb(0, 4, 'h11);
      tick();
      applyStimulus(0, OP_ADD, 0, 2'b00, 0, 0, 0, 1);
      sampleCycle();
      checkOutput("byp_vld", iss_vld, 1);
      checkOutput("byp_data", iss_rdata[0], 'h11);
      endCycle();

      // Full station under backpressure, then drain.
      for (int i = 0; i < E; i++) begin
         applyStimulus(1, OP_MUL, 11 + i, 2'b00, 100 + i, 200 + i, i, 0);
         tick();
      end
      applyStimulus(0, OP_ADD, 0, 2'b00, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         sampleCycle();
         checkOutput("full_rdy", disp_rdy, 0);
         checkOutput("hold_tag", iss_tag, 11);
         endCycle();
      end
      iss_rdy = 1'b1;
      for (int i = 0; i < E; i++) begin
         sampleCycle();
         checkOutput("drain_tag", iss_tag, 11 + i);
         endCycle();
      end
      tick();

      // Ordering: older entry sits in the higher slot.
      applyStimulus(1, OP_OR, 20, 2'b00, 1, 1, 0, 1);
      tick();
      applyStimulus(1, OP_OR, 1, 2'b01, 25, 3, 0, 1);
      tick();
      applyStimulus(1, OP_OR, 2, 2'b00, 4, 5, 0, 1);
      setCdb(0, 25, 'h55);
      tick();
      applyStimulus(0, OP_ADD, 0, 2'b00, 0, 0, 0, 1);
      first_tag = AGE ? 1 : 2;
      sampleCycle();
      checkOutput("order_first", iss_tag, first_tag);
      endCycle();
      sampleCycle();
      checkOutput("order_second", iss_tag, 3 - first_tag);
      endCycle();

      // Flush with three valid entries and a concurrent dispatch.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, OP_XOR, 40 + i, 2'b00, i, i, 0, 0);
         tick();
      end
      applyStimulus(1, OP_XOR, 30, 2'b00, 9, 9, 0, 0);
      flush = 1'b1;
      sampleCycle();
      checkOutput("flush_vld", iss_vld, 0);
      endCycle();
      applyStimulus(0, OP_ADD, 0, 2'b00, 0, 0, 0, 1);
      sampleCycle();
      checkOutput("flush_occ", occupancy, 0);
      checkOutput("flush_iss", iss_vld, 0);
      endCycle();
      for (int i = 0; i < 3; i++) tick();

      // Randomized phase: small tag space so wake-ups and multi-channel
      // matches occur often.
      for (int n = 0; n < 3000; n++) begin
         applyStimulus($urandom_range(0, 9) < 6, opcode_t'($urandom_range(0, 7)),
                       $urandom_range(0, 31), 2'($urandom_range(0, 3)),
                       0, 0, $urandom(), $urandom_range(0, 9) < 7);
         for (int k = 0; k < 2; k++) begin
            w = $urandom();
            w[TW-1:0] = TW'($urandom_range(0, 7));
            disp_opr[k] = w;
         end
         for (int c = 0; c < C; c++) begin
            if ($urandom_range(0, 2) == 0) setCdb(c, $urandom_range(0, 7), $urandom());
         end
         flush = ($urandom_range(0, 49) == 0);
         rst   = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      applyStimulus(0, OP_ADD, 0, 2'b00, 0, 0, 0, 1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
